pa_spsram_init_wrap: RTL
========================

// Module: pa_spsram_init_wrap
// PURPOSE
//  Parametrised single-port SRAM wrapper: next generation of the fixed-size IFU spsram wrappers.
//  Adds a hardware clear sequencer that writes INIT_VALUE to every entry after reset or on request.
//  Adds a selectable output pipeline stage and a read-valid strobe.
//  Sits between IFU/LSU cache/predictor tables and the storage array; replaces per-size wrappers.
// PARAMETERS
//  ADDR_WIDTH  5       address bits; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH  47      data bits per entry
//  WE_WIDTH    47      write-mask bits; each covers DATA_WIDTH/WE_WIDTH data bits (must divide exactly)
//  INIT_VALUE  0       DATA_WIDTH-bit pattern written by the clear sequencer
//  OUT_REG     0       0: Q valid 1 cycle after read; 1: extra flop, Q valid 2 cycles after read
// PORTS
//  forever_cpuclk  in   1           clock; all logic posedge
//  cpurst_b        in   1           async active-low reset
//  init_req        in   1           pulse: start a full clear sweep
//  A               in   ADDR_WIDTH  access address
//  CEN             in   1           chip enable, active low
//  GWEN            in   1           global write enable, active low (1 = read)
//  WEN             in   WE_WIDTH    per-slice write enable, active low (0 = write slice)
//  D               in   DATA_WIDTH  write data
//  Q               out  DATA_WIDTH  read data
//  q_vld           out  1           one-cycle strobe: Q carries new read data this cycle
//  init_busy       out  1           clear sweep in progress; user accesses are dropped
// BEHAVIOUR
//  - Reset values: Q=0, q_vld=0, init_busy=1, FSM=INIT, sweep counter=0. Array contents are not reset.
//  - FSM states: INIT, IDLE.
//    - INIT: each cycle write INIT_VALUE (all slices) to address cnt, then cnt++.
//    - On the write to cnt==DEPTH-1, go to IDLE; init_busy=0 from the next cycle.
//    - A sweep therefore takes exactly DEPTH cycles after reset release.
//    - IDLE -> INIT on init_req=1: cnt cleared; init_busy=1 from the next cycle.
//    - init_req while in INIT: ignored; the sweep does not restart.
//  - Reset asserted mid-sweep: the sweep restarts from address 0 on release.
//    Partially cleared contents are not relied upon.
//  - User access is sampled only when init_busy=0 and init_req=0.
//    Otherwise the access is silently dropped: no write, no q_vld.
//    If init_req and an access coincide in IDLE, init wins.
//  - Write (CEN=0, GWEN=0): slice i of D is written where WEN[i]=0; other slices keep their contents.
//    Q and q_vld are unchanged. There is no write-through.
//  - Read (CEN=0, GWEN=1): array[A] is registered.
//    OUT_REG=0: Q and q_vld=1 at cycle N+1. OUT_REG=1: both at cycle N+2.
//  - Back-to-back reads: one per cycle, fully pipelined, in order.
//  - Q holds the last read data until the next read completes. It is not cleared by the sweep.
//  - CEN=1: no array access. WEN and D are don't-care.
//  - Reading an address in the same cycle as it is written cannot occur on a single port.
// STRUCTURE
//  - Shared package pa_spsram_pkg: FSM state encoding (INIT/IDLE) and a WE_WIDTH-divisibility check macro.
//  - Sub-module pa_spsram_array: the behavioural storage.
//    Inputs: registered read port, masked write, no reset, same port set as the legacy FPGA array.
//    This is the only piece swapped for a foundry macro in ASIC builds.
//  - Top level holds the sweep FSM and counter, the access mux (sweep vs user), the OUT_REG stage and q_vld.
// TESTING
//  1 Reset release, DEPTH=32: init_busy stays 1 for 32 cycles, then falls.
//    Read every address -> Q==INIT_VALUE, with q_vld on each read.
//  2 Write D=47'h1234_5678_9AB at A=5 with WEN all 0, then read A=5:
//    OUT_REG=0 -> Q valid next cycle; OUT_REG=1 -> two cycles later; q_vld one cycle wide.
//  3 Masked write, WE_WIDTH=47: WEN=47'h7FFF_FFFF_FFF0 (low 4 bits enabled), D=all-ones
//    over an entry holding 0 -> readback 47'h000_0000_000F.
//  4 Reads A=0,1,2,3 on consecutive cycles -> 4 consecutive q_vld, in order.
//    A write between reads leaves Q unchanged.
//  5 init_req in IDLE in the same cycle as a write to A=7: write dropped.
//    After 32 cycles init_busy=0 and A=7 reads INIT_VALUE. A second init_req mid-sweep does not extend it.
//  6 Assert cpurst_b=0 at sweep cycle 10:
//    Q=0, q_vld=0, init_busy=1 immediately. After release, a full 32-cycle sweep occurs.

Source files
------------

// File: rtl/pa_spsram_pkg.sv
// ---------------------------------------------------------------------------
// pa_spsram_pkg
// Shared definitions for the parametrised single-port SRAM wrapper family.
//   - sweep_state_e : encoding of the clear-sequencer FSM (INIT / IDLE)
//   - PA_SPSRAM_WE_DIV_OK(dw, ww) : true when the write mask width divides
//     the data width exactly, so every mask bit owns a whole data slice
//   - slice_width() : number of data bits controlled by one mask bit
// No ports; imported by pa_spsram_array and pa_spsram_init_wrap.
// ---------------------------------------------------------------------------
`ifndef PA_SPSRAM_PKG_SV
`define PA_SPSRAM_PKG_SV

`define PA_SPSRAM_WE_DIV_OK(dw, ww) (((ww) > 0) && (((dw) % (ww)) == 0))

package pa_spsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } sweep_state_e;

    function automatic int slice_width(input int dw, input int ww);
        return dw / ww;
    endfunction

endpackage

`endif

// File: rtl/pa_spsram_array.sv
// ---------------------------------------------------------------------------
// pa_spsram_array
// Behavioural single-port storage with a registered read port and a
// slice-masked write. Same port set as the legacy FPGA array so a foundry
// macro can be dropped in its place. The storage and read register are not
// reset.
// Ports:
//   clk   in  1           clock, posedge
//   a     in  ADDR_WIDTH  address
//   cen   in  1           chip enable, active low
//   gwen  in  1           global write enable, active low (1 = read)
//   wen   in  WE_WIDTH    per-slice write enable, active low
//   d     in  DATA_WIDTH  write data
//   q     out DATA_WIDTH  read data, updated only by a read, held otherwise
// ---------------------------------------------------------------------------
module pa_spsram_array
    import pa_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 47,
    parameter int WE_WIDTH   = 47
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic                  cen,
    input  logic                  gwen,
    input  logic [WE_WIDTH-1:0]   wen,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SLICE = slice_width(DATA_WIDTH, WE_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] bit_mask;

    // Expand the active-low slice enables into a per-bit write mask
    // (1 = this bit takes the new data).
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
        assign bit_mask[i] = ~wen[i / SLICE];
    end

    // Single port: a cycle is either a masked write or a registered read,
    // never both. Unmasked bits of a written entry keep their contents.
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                mem[a] <= (mem[a] & ~bit_mask) | (d & bit_mask);
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/pa_spsram_init_wrap.sv
// ---------------------------------------------------------------------------
// pa_spsram_init_wrap
// Parametrised single-port SRAM wrapper with a hardware clear sequencer.
// After reset, or on init_req while idle, every entry is written with
// INIT_VALUE, one entry per cycle. User accesses are dropped while the
// sweep runs (and in the cycle init_req is accepted). Reads produce Q with
// a one-cycle q_vld strobe, one cycle after the read (OUT_REG=0) or two
// cycles after (OUT_REG=1).
// Ports:
//   forever_cpuclk in  1           clock, posedge
//   cpurst_b       in  1           async active-low reset
//   init_req       in  1           start a full clear sweep (ignored if busy)
//   A              in  ADDR_WIDTH  access address
//   CEN            in  1           chip enable, active low
//   GWEN           in  1           global write enable, active low (1 = read)
//   WEN            in  WE_WIDTH    per-slice write enable, active low
//   D              in  DATA_WIDTH  write data
//   Q              out DATA_WIDTH  read data, held until the next read lands
//   q_vld          out 1           Q carries new read data this cycle
//   init_busy      out 1           clear sweep in progress
// ---------------------------------------------------------------------------
module pa_spsram_init_wrap
    import pa_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 47,
    parameter int                    WE_WIDTH   = 47,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    OUT_REG    = 0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  q_vld,
    output logic                  init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // A mask bit must own a whole number of data bits.
    if (!`PA_SPSRAM_WE_DIV_OK(DATA_WIDTH, WE_WIDTH)) begin : g_bad_we_width
        $error("pa_spsram_init_wrap: WE_WIDTH must divide DATA_WIDTH exactly");
    end

    sweep_state_e          state;
    sweep_state_e          state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    logic                  user_ok;
    logic                  user_rd;
    logic                  rd_vld1;

    logic [ADDR_WIDTH-1:0] arr_a;
    logic                  arr_cen;
    logic                  arr_gwen;
    logic [WE_WIDTH-1:0]   arr_wen;
    logic [DATA_WIDTH-1:0] arr_d;
    logic [DATA_WIDTH-1:0] arr_q;

    // Sweep FSM state and address counter.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // INIT walks the counter through every address and leaves after the
    // last one; the counter wraps to 0 on its own at that point. IDLE only
    // leaves on init_req, which restarts the counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign init_busy = (state == ST_INIT);

    // A pending init_req takes priority over a coincident user access.
    assign user_ok = (state == ST_IDLE) && !init_req;
    assign user_rd = user_ok && !CEN && GWEN;

    // Port mux: the sweep owns the array while busy; otherwise the user
    // access passes through only when it is accepted.
    always_comb begin
        arr_a    = A;
        arr_cen  = 1'b1;
        arr_gwen = GWEN;
        arr_wen  = WEN;
        arr_d    = D;
        if (init_busy) begin
            arr_a    = cnt;
            arr_cen  = 1'b0;
            arr_gwen = 1'b0;
            arr_wen  = '0;
            arr_d    = INIT_VALUE;
        end else if (user_ok) begin
            arr_cen  = CEN;
        end
    end

    pa_spsram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_array (
        .clk  (forever_cpuclk),
        .a    (arr_a),
        .cen  (arr_cen),
        .gwen (arr_gwen),
        .wen  (arr_wen),
        .d    (arr_d),
        .q    (arr_q)
    );

    // First-stage read strobe: array output is fresh in this cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld1 <= 1'b0;
        end else begin
            rd_vld1 <= user_rd;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_pipe;
        logic                  rd_vld2;

        // Extra output stage: capture the array data only when it is new,
        // so Q holds the last read.
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q_pipe  <= '0;
                rd_vld2 <= 1'b0;
            end else begin
                rd_vld2 <= rd_vld1;
                if (rd_vld1) begin
                    q_pipe <= arr_q;
                end
            end
        end

        assign Q     = q_pipe;
        assign q_vld = rd_vld2;
    end else begin : g_no_out_reg
        logic rd_seen;

        // The array read register has no reset, so Q is forced to 0 until
        // the first read since reset has landed. After that the array
        // register itself holds the last read data.
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                rd_seen <= 1'b0;
            end else if (user_rd) begin
                rd_seen <= 1'b1;
            end
        end

        assign Q     = rd_seen ? arr_q : '0;
        assign q_vld = rd_vld1;
    end

endmodule
